// File: rtl/ps2_keyboard_receiver_pkg.sv
// PS/2 keyboard receiver shared constants and types.
// Optional odd-parity check: HACK_PS2_PARITY_CHECK_EN.
package ps2_keyboard_receiver_pkg;

  localparam logic [7:0] HACK_KEY_NEWLINE   = 8'd128;
  localparam logic [7:0] HACK_KEY_BACKSPACE = 8'd129;
  localparam logic [7:0] HACK_KEY_LEFT      = 8'd130;
  localparam logic [7:0] HACK_KEY_UP        = 8'd131;
  localparam logic [7:0] HACK_KEY_RIGHT     = 8'd132;
  localparam logic [7:0] HACK_KEY_DOWN      = 8'd133;
  localparam logic [7:0] HACK_KEY_HOME      = 8'd134;
  localparam logic [7:0] HACK_KEY_END       = 8'd135;
  localparam logic [7:0] HACK_KEY_PGUP      = 8'd136;
  localparam logic [7:0] HACK_KEY_PGDN      = 8'd137;
  localparam logic [7:0] HACK_KEY_INSERT    = 8'd138;
  localparam logic [7:0] HACK_KEY_DELETE    = 8'd139;
  localparam logic [7:0] HACK_KEY_ESC       = 8'd140;
  localparam logic [7:0] HACK_KEY_F1        = 8'd141;
  localparam logic [7:0] HACK_KEY_F2        = 8'd142;
  localparam logic [7:0] HACK_KEY_F3        = 8'd143;
  localparam logic [7:0] HACK_KEY_F4        = 8'd144;
  localparam logic [7:0] HACK_KEY_F5        = 8'd145;
  localparam logic [7:0] HACK_KEY_F6        = 8'd146;
  localparam logic [7:0] HACK_KEY_F7        = 8'd147;
  localparam logic [7:0] HACK_KEY_F8        = 8'd148;
  localparam logic [7:0] HACK_KEY_F9        = 8'd149;
  localparam logic [7:0] HACK_KEY_F10       = 8'd150;
  localparam logic [7:0] HACK_KEY_F11       = 8'd151;
  localparam logic [7:0] HACK_KEY_F12       = 8'd152;

  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PS2_SHIFT_L      = 8'h12;
  localparam logic [7:0] PS2_SHIFT_R      = 8'h59;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } ps2_state_t;

  typedef struct packed {
    logic       ext;
    logic [7:0] code;
  } key_ev_t;

  function automatic logic is_shift_key(key_ev_t ev);
    return !ev.ext &&
      (ev.code == PS2_SHIFT_L || ev.code == PS2_SHIFT_R);
  endfunction

endpackage

// File: rtl/ps2_keyboard_receiver_if.sv
// PS/2 receiver pin and result bundle.
// master = receiver side, slave = keyboard/consumer side.
interface ps2_keyboard_receiver_if #(
  parameter int KEYCODE_WIDTH = 8
);
  logic                     ps2_clk;
  logic                     ps2_data;
  logic [KEYCODE_WIDTH-1:0] keycode;
  logic                     frame_error;
  logic                     scancode_valid;
  logic [7:0]               scancode;

  modport master (
    input  ps2_clk,
    input  ps2_data,
    output keycode,
    output frame_error,
    output scancode_valid,
    output scancode
  );

  modport slave (
    output ps2_clk,
    output ps2_data,
    input  keycode,
    input  frame_error,
    input  scancode_valid,
    input  scancode
  );
endinterface

// File: rtl/ps2_scancode_to_hack.sv
// Combinational PS/2 set-2 {ext, shift, scancode} to Hack code table.
// Unmapped keys return 0; keypad keys ignore shift.
module ps2_scancode_to_hack
  import ps2_keyboard_receiver_pkg::*;
(
  input  logic       ext,
  input  logic       shift,
  input  logic [7:0] scancode,
  output logic [7:0] hack
);

  // {unshifted, shifted}
  logic [15:0] pair;

  always_comb begin
    pair = '0;
    if (ext) begin
      case (scancode)
        8'h6B:   pair = {2{HACK_KEY_LEFT}};
        8'h75:   pair = {2{HACK_KEY_UP}};
        8'h74:   pair = {2{HACK_KEY_RIGHT}};
        8'h72:   pair = {2{HACK_KEY_DOWN}};
        8'h6C:   pair = {2{HACK_KEY_HOME}};
        8'h69:   pair = {2{HACK_KEY_END}};
        8'h7D:   pair = {2{HACK_KEY_PGUP}};
        8'h7A:   pair = {2{HACK_KEY_PGDN}};
        8'h70:   pair = {2{HACK_KEY_INSERT}};
        8'h71:   pair = {2{HACK_KEY_DELETE}};
        8'h5A:   pair = {2{HACK_KEY_NEWLINE}};
        8'h4A:   pair = {2{8'h2F}};
        default: pair = '0;
      endcase
    end else begin
      case (scancode)
        8'h1C: pair = {8'h61, 8'h41};
        8'h32: pair = {8'h62, 8'h42};
        8'h21: pair = {8'h63, 8'h43};
        8'h23: pair = {8'h64, 8'h44};
        8'h24: pair = {8'h65, 8'h45};
        8'h2B: pair = {8'h66, 8'h46};
        8'h34: pair = {8'h67, 8'h47};
        8'h33: pair = {8'h68, 8'h48};
        8'h43: pair = {8'h69, 8'h49};
        8'h3B: pair = {8'h6A, 8'h4A};
        8'h42: pair = {8'h6B, 8'h4B};
        8'h4B: pair = {8'h6C, 8'h4C};
        8'h3A: pair = {8'h6D, 8'h4D};
        8'h31: pair = {8'h6E, 8'h4E};
        8'h44: pair = {8'h6F, 8'h4F};
        8'h4D: pair = {8'h70, 8'h50};
        8'h15: pair = {8'h71, 8'h51};
        8'h2D: pair = {8'h72, 8'h52};
        8'h1B: pair = {8'h73, 8'h53};
        8'h2C: pair = {8'h74, 8'h54};
        8'h3C: pair = {8'h75, 8'h55};
        8'h2A: pair = {8'h76, 8'h56};
        8'h1D: pair = {8'h77, 8'h57};
        8'h22: pair = {8'h78, 8'h58};
        8'h35: pair = {8'h79, 8'h59};
        8'h1A: pair = {8'h7A, 8'h5A};
        8'h45: pair = {8'h30, 8'h29};
        8'h16: pair = {8'h31, 8'h21};
        8'h1E: pair = {8'h32, 8'h40};
        8'h26: pair = {8'h33, 8'h23};
        8'h25: pair = {8'h34, 8'h24};
        8'h2E: pair = {8'h35, 8'h25};
        8'h36: pair = {8'h36, 8'h5E};
        8'h3D: pair = {8'h37, 8'h26};
        8'h3E: pair = {8'h38, 8'h2A};
        8'h46: pair = {8'h39, 8'h28};
        8'h0E: pair = {8'h60, 8'h7E};
        8'h4E: pair = {8'h2D, 8'h5F};
        8'h55: pair = {8'h3D, 8'h2B};
        8'h5D: pair = {8'h5C, 8'h7C};
        8'h54: pair = {8'h5B, 8'h7B};
        8'h5B: pair = {8'h5D, 8'h7D};
        8'h4C: pair = {8'h3B, 8'h3A};
        8'h52: pair = {8'h27, 8'h22};
        8'h41: pair = {8'h2C, 8'h3C};
        8'h49: pair = {8'h2E, 8'h3E};
        8'h4A: pair = {8'h2F, 8'h3F};
        8'h29: pair = {2{8'h20}};
        8'h70: pair = {2{8'h30}};
        8'h69: pair = {2{8'h31}};
        8'h72: pair = {2{8'h32}};
        8'h7A: pair = {2{8'h33}};
        8'h6B: pair = {2{8'h34}};
        8'h73: pair = {2{8'h35}};
        8'h74: pair = {2{8'h36}};
        8'h6C: pair = {2{8'h37}};
        8'h75: pair = {2{8'h38}};
        8'h7D: pair = {2{8'h39}};
        8'h71: pair = {2{8'h2E}};
        8'h7C: pair = {2{8'h2A}};
        8'h7B: pair = {2{8'h2D}};
        8'h79: pair = {2{8'h2B}};
        8'h5A: pair = {2{HACK_KEY_NEWLINE}};
        8'h66: pair = {2{HACK_KEY_BACKSPACE}};
        8'h76: pair = {2{HACK_KEY_ESC}};
        8'h05: pair = {2{HACK_KEY_F1}};
        8'h06: pair = {2{HACK_KEY_F2}};
        8'h04: pair = {2{HACK_KEY_F3}};
        8'h0C: pair = {2{HACK_KEY_F4}};
        8'h03: pair = {2{HACK_KEY_F5}};
        8'h0B: pair = {2{HACK_KEY_F6}};
        8'h83: pair = {2{HACK_KEY_F7}};
        8'h0A: pair = {2{HACK_KEY_F8}};
        8'h01: pair = {2{HACK_KEY_F9}};
        8'h09: pair = {2{HACK_KEY_F10}};
        8'h78: pair = {2{HACK_KEY_F11}};
        8'h07: pair = {2{HACK_KEY_F12}};
        default: pair = '0;
      endcase
    end
    hack = shift ? pair[7:0] : pair[15:8];
  end

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 set-2 keyboard receiver producing the Hack KBD keycode.
// Define HACK_PS2_PARITY_CHECK_EN to reject frames with bad odd parity.
module ps2_keyboard_receiver
  import ps2_keyboard_receiver_pkg::*;
#(
  parameter int FILTER_CLKS   = 8,
  parameter int TIMEOUT_CLKS  = 25000,
  parameter int KEYCODE_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  ps2_keyboard_receiver_if.master  bus
);

  localparam int FW =
    (FILTER_CLKS > 1) ? $clog2(FILTER_CLKS) : 1;
  localparam int TW =
    (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

  // bit 0 = ps2_clk, bit 1 = ps2_data
  logic [1:0]    s1, s2, filt, filt_q;
  logic [FW-1:0] fcnt [2];
  logic          fall, din;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1     <= '1;
      s2     <= '1;
      filt   <= '1;
      filt_q <= '1;
      for (int i = 0; i < 2; i++) fcnt[i] <= '0;
    end else begin
      s1     <= {bus.ps2_data, bus.ps2_clk};
      s2     <= s1;
      filt_q <= filt;
      for (int i = 0; i < 2; i++) begin
        if (s2[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_CLKS - 1)) begin
          filt[i] <= s2[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  assign fall = filt_q[0] & ~filt[0];
  assign din  = filt[1];

  ps2_state_t    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic [TW-1:0] tmo;
  logic          ferr_q, sv_q;
  logic [7:0]    sc_q;
  logic          good;

`ifdef HACK_PS2_PARITY_CHECK_EN
  logic par_q;
  assign good = ^{shreg, par_q};
`else
  assign good = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      tmo     <= '0;
      ferr_q  <= 1'b0;
      sv_q    <= 1'b0;
      sc_q    <= '0;
`ifdef HACK_PS2_PARITY_CHECK_EN
      par_q   <= 1'b0;
`endif
    end else begin
      ferr_q <= 1'b0;
      sv_q   <= 1'b0;
      if (fall) begin
        tmo <= '0;
        unique case (state)
          ST_IDLE: begin
            if (!din) begin
              state   <= ST_DATA;
              bit_cnt <= '0;
            end else begin
              ferr_q <= 1'b1;
            end
          end
          ST_DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
          ST_PARITY: begin
`ifdef HACK_PS2_PARITY_CHECK_EN
            par_q <= din;
`endif
            state <= ST_STOP;
          end
          ST_STOP: begin
            state <= ST_IDLE;
            if (din && good) begin
              sv_q <= 1'b1;
              sc_q <= shreg;
            end else begin
              ferr_q <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end else if (state != ST_IDLE) begin
        // a stalled keyboard must not wedge the frame FSM
        if (tmo == TW'(TIMEOUT_CLKS - 1)) begin
          ferr_q <= 1'b1;
          state  <= ST_IDLE;
          tmo    <= '0;
        end else begin
          tmo <= tmo + 1'b1;
        end
      end
    end
  end

  logic                     ext_q, brk_q;
  logic [1:0]               shift_q;
  key_ev_t                  held_q, ev;
  logic [KEYCODE_WIDTH-1:0] kc_q;
  logic [7:0]               xlat;
  logic                     is_ext, is_brk, is_shift;

  ps2_scancode_to_hack u_xlat (
    .ext      (ext_q),
    .shift    (|shift_q),
    .scancode (sc_q),
    .hack     (xlat)
  );

  assign ev       = '{ext: ext_q, code: sc_q};
  assign is_ext   = sc_q == PS2_PREFIX_EXT;
  assign is_brk   = sc_q == PS2_PREFIX_BREAK;
  assign is_shift = is_shift_key(ev);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      shift_q <= '0;
      held_q  <= '0;
      kc_q    <= '0;
    end else if (sv_q) begin
      unique case (1'b1)
        is_ext: ext_q <= 1'b1;
        is_brk: brk_q <= 1'b1;
        is_shift: begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          shift_q[sc_q == PS2_SHIFT_R] <= !brk_q;
        end
        default: begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (!brk_q) begin
            if (xlat != 8'd0) begin
              kc_q   <= KEYCODE_WIDTH'(xlat);
              held_q <= ev;
            end
          end else if (held_q == ev) begin
            kc_q   <= '0;
            held_q <= '0;
          end
        end
      endcase
    end
  end

  assign bus.keycode        = kc_q;
  assign bus.frame_error    = ferr_q;
  assign bus.scancode_valid = sv_q;
  assign bus.scancode       = sc_q;

endmodule

// File: tb/tb_ps2_keyboard_receiver.sv
// Directed bench for ps2_keyboard_receiver: bit-banged PS/2 frames
// with hand-computed Hack keycodes checked by immediate assertions.
module tb_ps2_keyboard_receiver;

  localparam int HB      = 20;
  localparam int TIMEOUT = 25000;

  logic clk;
  logic reset;

  ps2_keyboard_receiver_if bus ();

  ps2_keyboard_receiver #(
    .FILTER_CLKS   (8),
    .TIMEOUT_CLKS  (TIMEOUT),
    .KEYCODE_WIDTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nvec = 0;
  int nmis = 0;
  int nvalid = 0;
  int nerr = 0;
  int cyc = 0;
  int valid_cyc = 0;
  int kc_cyc = 0;
  logic [7:0] last_sc = '0;
  logic [7:0] kc_prev = '0;

  always @(negedge clk) begin
    if (bus.scancode_valid === 1'b1) begin
      nvalid++;
      last_sc = bus.scancode;
      valid_cyc = cyc;
    end
    if (bus.frame_error === 1'b1) nerr++;
    if (bus.keycode !== kc_prev) begin
      kc_cyc = cyc;
      kc_prev = bus.keycode;
    end
    cyc++;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic v);
    bus.ps2_data = v;
    repeat (HB) @(posedge clk);
    bus.ps2_clk = 1'b0;
    repeat (HB) @(posedge clk);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic stop_b,
                            input logic par_bad);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ par_bad);
    ps2_bit(stop_b);
    bus.ps2_data = 1'b1;
    repeat (4 * HB) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b1, 1'b0);
  endtask

  int v0, e0;

  initial begin
    reset = 1'b0;
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("rst_keycode", bus.keycode, 0);
    check("rst_scancode", bus.scancode, 0);
    check("rst_frame_error", bus.frame_error, 0);
    check("rst_valid", bus.scancode_valid, 0);
    reset = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("idle_no_err", nerr, 0);

    v0 = nvalid;
    key(8'h1C);
    check("a_valid_cnt", nvalid - v0, 1);
    check("a_scancode", last_sc, 8'h1C);
    check("a_keycode", bus.keycode, 97);
    check("a_latency", kc_cyc - valid_cyc, 1);
    key(8'hF0); key(8'h1C);
    check("a_release", bus.keycode, 0);

    key(8'h12); key(8'h1C);
    check("shift_a", bus.keycode, 65);
    key(8'hF0); key(8'h12);
    check("shift_rel_keep", bus.keycode, 65);
    key(8'hF0); key(8'h1C);
    check("shift_a_rel", bus.keycode, 0);

    key(8'hE0); key(8'h75);
    check("up_make", bus.keycode, 131);
    key(8'hE0); key(8'hF0); key(8'h75);
    check("up_break", bus.keycode, 0);
    key(8'h75);
    check("kp8_make", bus.keycode, 56);
    key(8'hF0); key(8'h75);
    check("kp8_break", bus.keycode, 0);

    key(8'h1C); key(8'h32);
    check("b_over_a", bus.keycode, 98);
    key(8'hF0); key(8'h1C);
    check("rel_a_keep_b", bus.keycode, 98);
    key(8'hF0); key(8'h32);
    check("rel_b", bus.keycode, 0);

    e0 = nerr; v0 = nvalid;
    send_frame(8'h1C, 1'b0, 1'b0);
    check("badstop_err", nerr - e0, 1);
    check("badstop_novalid", nvalid - v0, 0);
    check("badstop_keycode", bus.keycode, 0);

    e0 = nerr; v0 = nvalid;
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef HACK_PS2_PARITY_CHECK_EN
    check("badpar_err", nerr - e0, 1);
    check("badpar_novalid", nvalid - v0, 0);
    check("badpar_keycode", bus.keycode, 0);
`else
    check("par_ignored_err", nerr - e0, 0);
    check("par_ignored_valid", nvalid - v0, 1);
    check("par_ignored_keycode", bus.keycode, 97);
    key(8'hF0); key(8'h1C);
    check("par_ignored_rel", bus.keycode, 0);
`endif

    e0 = nerr;
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    bus.ps2_data = 1'b1;
    repeat (TIMEOUT - 100) @(posedge clk);
    #1;
    check("tmo_not_early", nerr - e0, 0);
    repeat (200) @(posedge clk);
    #1;
    check("tmo_err", nerr - e0, 1);
    v0 = nvalid;
    key(8'h5A);
    check("enter_valid", nvalid - v0, 1);
    check("enter_keycode", bus.keycode, 128);
    key(8'hF0); key(8'h5A);
    check("enter_rel", bus.keycode, 0);

    key(8'h1C);
    check("pre_rst_keycode", bus.keycode, 97);
    e0 = nerr; v0 = nvalid;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    bus.ps2_data = 1'b1;
    repeat (3) @(posedge clk);
    reset = 1'b0;
    #1;
    check("midrst_keycode", bus.keycode, 0);
    repeat (5) @(posedge clk);
    reset = 1'b1;
    repeat (4 * HB) @(posedge clk);
    #1;
    check("midrst_no_err", nerr - e0, 0);
    check("midrst_no_valid", nvalid - v0, 0);
    key(8'h1C);
    check("post_rst_keycode", bus.keycode, 97);
    check("post_rst_scancode", last_sc, 8'h1C);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_receiver.md
Name: ps2_keyboard_receiver

Overview:
- Upstream producer of the SoC `keycode` input.
- Receives PS/2 set-2 scancodes on the external ps2_clk/ps2_data pins, synchronised and glitch-filtered into `clk`.
- Decodes make, break and E0-extended sequences, tracks shift state, and translates to Hack keyboard codes.
- Holds the code of the most recently pressed key on `keycode`; drives 0 once that key is released, matching Hack KBD register semantics.

Parameters:
- FILTER_CLKS, 8: consecutive identical synchronised samples required before a PS/2 line level is accepted.
- TIMEOUT_CLKS, 25000: clk cycles with no accepted ps2_clk falling edge mid-frame before the frame is aborted (≈1 ms at 25 MHz).
- KEYCODE_WIDTH, 8: width of the keycode output.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ps2_clk  in  1  raw PS/2 clock from the keyboard (asynchronous).
- ps2_data  in  1  raw PS/2 data from the keyboard (asynchronous).
- keycode  out  KEYCODE_WIDTH  Hack code of the currently held key; 0 when no key is held.
- frame_error  out  1  one-clk pulse when a frame is discarded (bad start/stop, timeout, or parity when enabled).
- scancode_valid  out  1  one-clk pulse when a good frame is received.
- scancode  out  8  raw byte of the last good frame; valid while scancode_valid is high.

Behaviour:
- Reset (reset=0, asynchronous):
  - keycode=0, frame_error=0, scancode_valid=0, scancode=0.
  - FSM returns to IDLE; shift, E0 and F0 flags clear; held-key register clears.
  - Synchronisers and filters preset to 1 (idle bus).
  - Reset mid-frame discards the partial frame with no pulse.
- Input conditioning:
  - Each line passes through a 2-FF synchroniser, then a saturating filter counter.
  - The filtered level changes only after FILTER_CLKS equal samples.
  - A falling edge is a filtered ps2_clk transition 1→0, asserted for one clk.
- Frame FSM (advances only on falling edges):
  - IDLE → DATA when data=0 (start bit). If data=1 at the edge: frame_error pulse, stay IDLE.
  - DATA: shift in 8 bits LSB first; 3-bit counter; after bit 7 → PARITY.
  - PARITY: latch the bit → STOP.
  - STOP: if data=1 and the frame is good, pulse scancode_valid the next clk, then → IDLE. If data=0, pulse frame_error, then → IDLE.
  - Timeout counter resets on every falling edge and is active in DATA/PARITY/STOP. At TIMEOUT_CLKS it pulses frame_error and forces IDLE.
  - Timeout and an edge in the same clk: the edge wins.
- Decoder (acts on scancode_valid):
  - 0xE0 sets the ext flag.
  - 0xF0 sets the brk flag.
  - Any other byte is a key event {ext, byte}; both flags clear after it.
  - Make of 0x12 or 0x59 (ext=0) sets the corresponding shift bit; break clears it. Shift events never alter keycode.
  - Other make: if the translation is nonzero, keycode ← translation and held-key ← {ext, byte}. Translation 0 (unmapped) leaves keycode unchanged.
  - Break: if {ext, byte} equals held-key, keycode ← 0 and held-key clears; otherwise no change.
  - Typematic repeat makes re-write the same value.
- Latency: keycode updates exactly 2 clks after the STOP-bit falling edge is detected.
- Translation (Hack codes):
  - Printable keys map to ASCII 32–126, shifted or unshifted.
  - Enter 128, Backspace 129, Left 130, Up 131, Right 132, Down 133, Home 134, End 135, PgUp 136, PgDn 137, Insert 138, Delete 139, Esc 140, F1–F12 141–152.

Optional Feature:
- Macro: HACK_PS2_PARITY_CHECK_EN.
- Defined: a frame is good only if the 8 data bits plus the parity bit have odd parity. A failing frame pulses frame_error instead of scancode_valid, and decoder state is unchanged.
- Undefined: the parity bit is sampled and ignored, and every frame with valid start/stop bits is good.

Decomposition:
- Shared params include holds:
  - Hack special-key codes (HACK_KEY_NEWLINE … HACK_KEY_F12).
  - PS/2 prefix constants (PS2_PREFIX_EXT=8'hE0, PS2_PREFIX_BREAK=8'hF0).
  - Shift scancodes.
- Sub-module: ps2_scancode_to_hack, a combinational {ext, shift, scancode} → Hack code table that returns 0 for unmapped keys.
- FSM, filters and decoder stay in the top module.

Test Plan:
- Frame 0x1C (A) → scancode_valid with scancode=0x1C; keycode=97. Then frames F0,1C → keycode=0.
- Frames 12, 1C (shift+A) → keycode=65. Then F0,12 → keycode stays 65. Then F0,1C → keycode=0.
- Frames E0,75 (Up) → keycode=131. Then E0,F0,75 → keycode=0. A plain 0x75 (keypad 8) gives keycode=56.
- Press 1C then 32 (B), then release 1C → keycode stays 98. Then release 32 → keycode=0.
- Stop bit 0 on frame 0x1C → one frame_error pulse, keycode unchanged. With the macro defined, a bad-parity frame gives the same response.
- Stop the frame after 5 data bits and idle TIMEOUT_CLKS → frame_error pulse. The next frame 0x5A is decoded and gives keycode=128.
- Assert reset while keycode=97 mid-frame → keycode=0 immediately. The next frame decodes correctly.
